multicycle_datapath: RTL and testbench
======================================

# multicycle_datapath

Parametrised multi-cycle MIPS-subset datapath, the successor to the single-cycle datapath. Instruction and data accesses share one external memory port with a req/ack handshake that tolerates any number of wait states. An internal phase sequencer steps each instruction through FETCH/DECODE/EXEC/MEM/WB. The existing combinational controller still supplies per-instruction control from `opc`/`func`/`zero`.

## Interface
Parameters:
- `XLEN`, 32: data, address and register width; legal values are 32 and 64. Instructions are always 32 bits, taken from `mem_rdata[31:0]`.
- `NREG`, 32: number of architectural registers, 2..32. Register index is `instr[..]` modulo `NREG`.
- `RESET_PC`, 0: PC value loaded at reset.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `RegDst`  in  2  write-register select: 0 = rt, 1 = rd, 2 = reg 31.
- `WDInp`  in  1  write-data select: 0 = MemToReg result, 1 = PC+4.
- `RegWrite`, `ALUSrc`, `MemRead`, `MemWrite`, `MemToReg`  in  1 each  same meaning as in the single-cycle datapath.
- `ALUOperation`  in  3  ALU opcode.
- `PCSrc`  in  2  next-PC select: 0 = PC+4, 1 = branch target, 2 = jump, 3 = B register.
- `opc`, `func`  out  6 each  `IR[31:26]` and `IR[5:0]`.
- `zero`  out  1  registered ALU zero flag.
- `instr_done`  out  1  one-cycle pulse in WB.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write strobe, valid while `mem_req` is high.
- `mem_addr`  out  XLEN  byte address.
- `mem_wdata`  out  XLEN  store data.
- `mem_rdata`  in  XLEN  read data, valid when `mem_ack` is high.
- `mem_ack`  in  1  transfer complete.

## Operation
- States are IDLE, FETCH, DECODE, EXEC, MEM and WB. State resets to IDLE, and IDLE moves to FETCH unconditionally.
- FETCH:
  - Drives `mem_req`=1, `mem_we`=0, `mem_addr`=PC.
  - On a clock edge with `mem_ack`=1: IR <= `mem_rdata[31:0]`, then go to DECODE. Otherwise stay in FETCH.
- DECODE: A <= RF[`IR[25:21]`], B <= RF[`IR[20:16]`].
- EXEC:
  - ALUOut <= ALU(A, `ALUSrc` ? sext(`IR[15:0]`) : B); `zero` <= ALU zero.
  - Next state is MEM if `MemRead`|`MemWrite`, else WB. If both are set, the access is a write.
- MEM:
  - Drives `mem_req`=1, `mem_addr`=ALUOut, `mem_we`=`MemWrite`, `mem_wdata`=B.
  - On `mem_ack`: MDR <= `mem_rdata` if this is a read, then go to WB.
- WB:
  - If `RegWrite`: RF[dst] <= `WDInp` ? PC+4 : (`MemToReg` ? MDR : ALUOut).
  - PC <= selected next PC. The branch target is PC+4+(sext<<2). The jump target is {PC[XLEN-1:28], `IR[25:0]`, 2'b00}.
  - Pulse `instr_done`, then go to FETCH.
- Register 0 always reads 0; writes to it are dropped.
- All arithmetic is modulo 2^XLEN; sext extends to XLEN.
- `mem_req` is decoded from state (FETCH or MEM only).
- `mem_addr`, `mem_we` and `mem_wdata` stay stable while `mem_req` is high. They read 0 when `mem_req` is low.
- `mem_ack` with `mem_req` low is ignored.
- Control inputs are sampled only in EXEC (`ALUSrc`, `ALUOperation`, `MemRead`, `MemWrite`), MEM (`MemWrite`) and WB (the rest). They may change freely in other states.

## Timing
- Reset (asynchronous, `rst`=0):
  - PC = `RESET_PC`.
  - IR, A, B, ALUOut, MDR and all RF entries = 0.
  - `zero`=0, `instr_done`=0, `mem_req`=0, state = IDLE.
- Reset in the middle of a handshake drops `mem_req` immediately. Any pending ack is discarded.
- Zero-wait memory (`mem_ack` high in the first request cycle):
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
- Each cycle of `mem_ack`=0 during a request adds exactly one cycle.
- `instr_done` goes high in the WB cycle, and the new PC is visible the cycle after.
- First fetch request: the second rising edge after `rst` deasserts.
- The register-file write in WB is visible to the next instruction's DECODE. No forwarding is needed.

## Configuration
- `MCDP_STALL_CNT_EN` defined:
  - Adds output `stall_cnt` [15:0].
  - Increments on every edge where `mem_req`=1 and `mem_ack`=0.
  - Saturates at 16'hFFFF and resets to 0.
- Undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Test plan
- Reset with `RESET_PC`=32'h100 and zero-wait memory holding `addi`-style R1=5 at 0x100:
  - First request: `mem_addr`=0x100.
  - `instr_done` in cycle 4.
  - R1=5.
  - Next fetch at 0x104.
- Load with `mem_ack` delayed 3 cycles in MEM:
  - `mem_addr`/`mem_we` held constant for 4 cycles.
  - Instruction takes 8 cycles.
  - MDR value 32'hDEADBEEF written to rt.
  - `stall_cnt`=3 when enabled.
- Store with B=32'h12345678 and ALUOut=0x40: one write request with `mem_we`=1, `mem_addr`=0x40, `mem_wdata`=0x12345678. RF is unchanged.
- Branch taken, PC=0x200, imm=-2:
  - `zero`=1.
  - `PCSrc`=1.
  - Next fetch address 0x1FC.
- Jump-and-link with `RegDst`=2, `WDInp`=1, PC=0x300, target field 0x40:
  - R31=0x304.
  - Next fetch 0x100.
- Drop `rst` while FETCH is waiting for ack:
  - `mem_req` falls asynchronously.
  - After release, refetch from `RESET_PC`.
  - A late `mem_ack` is ignored.
  - Write attempt to R0 leaves it reading 0.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset datapath sharing one req/ack memory port between fetch and data access.
// Optional feature: define MCDP_STALL_CNT_EN to add the saturating wait-state counter output stall_cnt.
module multicycle_datapath #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      RegDst,
  input  logic            WDInp,
  input  logic            RegWrite,
  input  logic            ALUSrc,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            MemToReg,
  input  logic [2:0]      ALUOperation,
  input  logic [1:0]      PCSrc,
  output logic [5:0]      opc,
  output logic [5:0]      func,
  output logic            zero,
  output logic            instr_done,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
`ifdef MCDP_STALL_CNT_EN
  output logic [15:0]     stall_cnt,
`endif
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack
);

  localparam int unsigned RIW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_t;

  state_t          state, nextState;
  logic [XLEN-1:0] pc, regA, regB, aluOut, mdr;
  logic [31:0]     ir;
  logic [XLEN-1:0] rf [NREG];

  logic [XLEN-1:0] immExt, aluB, aluRes, pcPlus4, branchTgt, jumpTgt, pcNext, wbData;
  logic [XLEN-1:0] rdA, rdB;
  logic [RIW-1:0]  rsIdx, rtIdx, rdIdx, dstIdx;

  // Architectural register index is the instruction field modulo NREG.
  function automatic logic [RIW-1:0] regIdx(input logic [4:0] f);
    return RIW'(32'(f) % NREG);
  endfunction

  assign opc   = ir[31:26];
  assign func  = ir[5:0];
  assign rsIdx = regIdx(ir[25:21]);
  assign rtIdx = regIdx(ir[20:16]);
  assign rdIdx = regIdx(ir[15:11]);
  assign rdA   = (rsIdx == '0) ? '0 : rf[rsIdx];
  assign rdB   = (rtIdx == '0) ? '0 : rf[rtIdx];

  assign immExt    = {{(XLEN-16){ir[15]}}, ir[15:0]};
  assign pcPlus4   = pc + XLEN'(4);
  assign branchTgt = pcPlus4 + (immExt << 2);
  assign jumpTgt   = {pc[XLEN-1:28], ir[25:0], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Phase sequencing and memory-port drive; the port is quiet outside FETCH/MEM.
  always_comb begin
    nextState = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE:   nextState = FETCH;
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) nextState = DECODE;
      end
      DECODE: nextState = EXEC;
      EXEC:   nextState = (MemRead || MemWrite) ? MEM : WB;
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = MemWrite;
        mem_addr  = aluOut;
        mem_wdata = regB;
        if (mem_ack) nextState = WB;
      end
      WB:      nextState = FETCH;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    aluB   = ALUSrc ? immExt : regB;
    aluRes = '0;
    case (ALUOperation)
      3'd0: aluRes = regA & aluB;
      3'd1: aluRes = regA | aluB;
      3'd2: aluRes = regA + aluB;
      3'd3: aluRes = regA ^ aluB;
      3'd4: aluRes = ~(regA | aluB);
      3'd5: aluRes = XLEN'(regA < aluB);
      3'd6: aluRes = regA - aluB;
      3'd7: aluRes = XLEN'($signed(regA) < $signed(aluB));
    endcase
  end

  always_comb begin
    pcNext = pcPlus4;
    case (PCSrc)
      2'd1:    pcNext = branchTgt;
      2'd2:    pcNext = jumpTgt;
      2'd3:    pcNext = regB;
      default: pcNext = pcPlus4;
    endcase
    case (RegDst)
      2'd0:    dstIdx = rtIdx;
      2'd1:    dstIdx = rdIdx;
      default: dstIdx = regIdx(5'd31);
    endcase
    wbData = WDInp ? pcPlus4 : (MemToReg ? mdr : aluOut);
  end

  // Per-phase datapath registers; instr_done is timed to coincide with WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= RESET_PC;
      ir         <= '0;
      regA       <= '0;
      regB       <= '0;
      aluOut     <= '0;
      mdr        <= '0;
      zero       <= 1'b0;
      instr_done <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else begin
      instr_done <= (nextState == WB);
      case (state)
        FETCH:  if (mem_ack) ir <= mem_rdata[31:0];
        DECODE: begin
          regA <= rdA;
          regB <= rdB;
        end
        EXEC: begin
          aluOut <= aluRes;
          zero   <= (aluRes == '0);
        end
        MEM:    if (mem_ack && !MemWrite) mdr <= mem_rdata;
        WB: begin
          if (RegWrite && dstIdx != '0) rf[dstIdx] <= wbData;
          pc <= pcNext;
        end
        default: ;
      endcase
    end
  end

`ifdef MCDP_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt <= '0;
    else if (mem_req && !mem_ack && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Randomised bench for multicycle_datapath: the bench acts as controller and memory and
// predicts every port value from an instruction-level model of the datapath.
module tb_multicycle_datapath;

  localparam logic [31:0] RST_PC = 32'h100;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JAL = 5, K_JR = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  RegDst, PCSrc;
  logic        WDInp, RegWrite, ALUSrc, MemRead, MemWrite, MemToReg;
  logic [2:0]  ALUOperation;
  logic [5:0]  opc, func;
  logic        zero, instr_done, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MCDP_STALL_CNT_EN
  logic [15:0] stall_cnt;
  int          expStall;
`endif

  multicycle_datapath #(.XLEN(32), .NREG(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .RegDst(RegDst), .WDInp(WDInp), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .ALUOperation(ALUOperation), .PCSrc(PCSrc), .opc(opc), .func(func), .zero(zero),
    .instr_done(instr_done), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
`ifdef MCDP_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int          nTests, nFail;
  logic [31:0] regs [32];
  logic [31:0] mpc;
  logic [31:0] dmem [logic [31:0]];

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (pc %0h)", tag, got, exp, mpc);
    end
  endtask

  // Unwritten locations hold a fixed address-derived pattern.
  function automatic logic [31:0] memRd(input logic [31:0] a);
    if (dmem.exists(a)) return dmem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] aluRef(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a ^ b;
      3'd4:    return ~(a | b);
      3'd5:    return (a < b) ? 32'd1 : 32'd0;
      3'd6:    return a - b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic int waitPick();
    return ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  task automatic randCtrl();
    RegDst = 2'($urandom); WDInp = 1'($urandom); RegWrite = 1'($urandom);
    ALUSrc = 1'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom);
    MemToReg = 1'($urandom); ALUOperation = 3'($urandom); PCSrc = 2'($urandom);
  endtask

  // Runs one instruction starting just after the negedge of its first FETCH cycle.
  task automatic doInstr(input logic [31:0] iw, input int kind, input logic [2:0] op,
                         input int fw, input int mw, input logic both);
    logic [4:0]  rs, rt, rd, dst;
    logic [31:0] a, b, imm, res, addr, rdVal, wbVal, nextPc, pc4, expAddr;
    logic [1:0]  cRegDst, cPCSrc;
    logic        cRegWrite, cALUSrc, cMemRead, cMemWrite, cMemToReg, cWDInp;
    logic        isMem, fetchPh, memPh, expReq;
    int          wbC;
    rs = iw[25:21]; rt = iw[20:16]; rd = iw[15:11];
    imm = {{16{iw[15]}}, iw[15:0]};
    a = regs[rs]; b = regs[rt];
    cRegDst = 2'd0; cPCSrc = 2'd0; cRegWrite = 1'b0; cALUSrc = 1'b0;
    cMemRead = 1'b0; cMemWrite = 1'b0; cMemToReg = 1'b0; cWDInp = 1'b0;
    case (kind)
      K_R:   begin cRegDst = 2'd1; cRegWrite = 1'b1; end
      K_I:   begin cALUSrc = 1'b1; cRegWrite = 1'b1; end
      K_LW:  begin cALUSrc = 1'b1; cMemRead = 1'b1; cMemToReg = 1'b1; cRegWrite = 1'b1; end
      K_SW:  begin cALUSrc = 1'b1; cMemWrite = 1'b1; cMemRead = both; end
      K_BR:  ;
      K_JAL: begin cRegDst = 2'd2; cWDInp = 1'b1; cRegWrite = 1'b1; cPCSrc = 2'd2; end
      default: cPCSrc = 2'd3;
    endcase
    res = aluRef(op, a, cALUSrc ? imm : b);
    if (kind == K_BR) cPCSrc = (res == 32'd0) ? 2'd1 : 2'd0;
    dmem[mpc] = iw;
    pc4 = mpc + 32'd4;
    isMem = cMemRead | cMemWrite;
    addr = res;
    rdVal = memRd(addr);
    wbVal = cWDInp ? pc4 : (cMemToReg ? rdVal : res);
    dst = (cRegDst == 2'd0) ? rt : ((cRegDst == 2'd1) ? rd : 5'd31);
    case (cPCSrc)
      2'd0:    nextPc = pc4;
      2'd1:    nextPc = pc4 + (imm << 2);
      2'd2:    nextPc = {mpc[31:28], iw[25:0], 2'b00};
      default: nextPc = b;
    endcase
    wbC = isMem ? fw + mw + 4 : fw + 3;

    for (int c = 0; c <= wbC; c++) begin
      fetchPh = (c <= fw);
      memPh   = isMem && (c >= fw + 3) && (c <= fw + 3 + mw);
      if (c >= fw + 2) begin
        RegDst = cRegDst; WDInp = cWDInp; RegWrite = cRegWrite; ALUSrc = cALUSrc;
        MemRead = cMemRead; MemWrite = cMemWrite; MemToReg = cMemToReg;
        ALUOperation = op; PCSrc = cPCSrc;
      end else begin
        randCtrl();
      end
      mem_rdata = $urandom;
      if (fetchPh) begin
        mem_ack = (c == fw);
        if (mem_ack) mem_rdata = iw;
      end else if (memPh) begin
        mem_ack = (c == fw + 3 + mw);
        if (mem_ack && !cMemWrite) mem_rdata = rdVal;
      end else begin
        mem_ack = 1'($urandom);
      end
      #1;
      expReq  = fetchPh || memPh;
      expAddr = fetchPh ? mpc : (memPh ? addr : 32'd0);
      checkVal($sformatf("req c%0d", c), mem_req, expReq);
      checkVal($sformatf("addr c%0d", c), mem_addr, expAddr);
      checkVal($sformatf("we c%0d", c), mem_we, memPh && cMemWrite);
      if (memPh) checkVal($sformatf("wdata c%0d", c), mem_wdata, b);
      else if (!expReq) checkVal($sformatf("wdata_idle c%0d", c), mem_wdata, 32'd0);
      checkVal($sformatf("done c%0d", c), instr_done, c == wbC);
      if (c == fw + 1) begin
        checkVal("opc", opc, iw[31:26]);
        checkVal("func", func, iw[5:0]);
      end
      if (c == wbC) begin
        checkVal("zero", zero, res == 32'd0);
`ifdef MCDP_STALL_CNT_EN
        expStall += fw + (isMem ? mw : 0);
        checkVal("stall_cnt", stall_cnt, (expStall > 65535) ? 65535 : expStall);
`endif
      end
      @(negedge clk);
    end

    if (cRegWrite && dst != 5'd0) regs[dst] = wbVal;
    if (cMemWrite) dmem[addr] = b;
    mpc = nextPc;
  endtask

  task automatic randInstr();
    int          kind;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic [2:0]  op;
    kind = $urandom_range(0, 6);
    rs = 5'($urandom); rt = 5'($urandom); imm = 16'($urandom); op = 3'($urandom);
    if (kind == K_LW || kind == K_SW) begin
      op = 3'd2;
      if ($urandom_range(0, 1) == 1) begin
        rs  = 5'd0;
        imm = 16'($urandom_range(0, 15) * 4);
      end
    end
    if (kind == K_BR) begin
      op = 3'd6;
      if ($urandom_range(0, 1) == 1) rt = rs;
    end
    doInstr({6'($urandom), rs, rt, imm}, kind, op, waitPick(), waitPick(), 1'($urandom));
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    mpc = RST_PC;
`ifdef MCDP_STALL_CNT_EN
    expStall = 0;
`endif
  endtask

  // Reset asserted while FETCH waits; a late ack around release must be ignored.
  task automatic resetMid();
    randCtrl();
    mem_ack = 1'b0; mem_rdata = $urandom;
    #1 checkVal("rm_req_wait", mem_req, 1'b1);
    @(negedge clk);
    #1 checkVal("rm_addr_wait", mem_addr, mpc);
    #1 rst = 1'b0;
    #1;
    checkVal("rm_req_async", mem_req, 1'b0);
    checkVal("rm_addr_async", mem_addr, 32'd0);
    checkVal("rm_opc", opc, 6'd0);
    checkVal("rm_zero", zero, 1'b0);
    mem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 checkVal("rm_idle_req", mem_req, 1'b0);
    @(negedge clk);
    modelReset();
  endtask

  initial begin
    nTests = 0; nFail = 0;
    rst = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    randCtrl();
    modelReset();
    #12;
    checkVal("rst_req", mem_req, 1'b0);
    checkVal("rst_we", mem_we, 1'b0);
    checkVal("rst_addr", mem_addr, 32'd0);
    checkVal("rst_wdata", mem_wdata, 32'd0);
    checkVal("rst_done", instr_done, 1'b0);
    checkVal("rst_zero", zero, 1'b0);
    checkVal("rst_opc", opc, 6'd0);
    checkVal("rst_func", func, 6'd0);
`ifdef MCDP_STALL_CNT_EN
    checkVal("rst_stall", stall_cnt, 16'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    #1 checkVal("idle_req", mem_req, 1'b0);
    @(negedge clk);

    doInstr({6'h08, 5'd0, 5'd1, 16'd5}, K_I, 3'd2, 0, 0, 1'b0);          // R1 = 5
    dmem[32'h20] = 32'hDEAD_BEEF;
    doInstr({6'h23, 5'd0, 5'd3, 16'h0020}, K_LW, 3'd2, 0, 3, 1'b0);      // load with 3 waits
    dmem[32'h80] = 32'h1234_5678;
    doInstr({6'h23, 5'd0, 5'd2, 16'h0080}, K_LW, 3'd2, 1, 0, 1'b0);
    doInstr({6'h2B, 5'd0, 5'd2, 16'h0040}, K_SW, 3'd2, 0, 0, 1'b0);      // store to 0x40
    doInstr({6'h03, 26'h80}, K_JAL, 3'd2, 0, 0, 1'b0);                   // to 0x200
    doInstr({6'h04, 5'd1, 5'd1, 16'hFFFE}, K_BR, 3'd6, 0, 0, 1'b0);      // taken, to 0x1FC
    doInstr({6'h03, 26'hC0}, K_JAL, 3'd2, 0, 0, 1'b0);                   // to 0x300
    doInstr({6'h03, 26'h40}, K_JAL, 3'd2, 0, 0, 1'b0);                   // R31 = 0x304, to 0x100
    doInstr({6'h2B, 5'd0, 5'd31, 16'h0044}, K_SW, 3'd2, 0, 1, 1'b1);     // expose R31

    for (int n = 0; n < 150; n++) randInstr();

    resetMid();
    doInstr({6'h08, 5'd0, 5'd0, 16'd7}, K_I, 3'd2, 0, 0, 1'b0);          // write to R0 dropped
    doInstr({6'h2B, 5'd0, 5'd0, 16'h0048}, K_SW, 3'd2, 0, 0, 1'b0);      // R0 still reads 0

    for (int n = 0; n < 60; n++) randInstr();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
